// File: rtl/cfg_ro_shadow_if.sv
// Update-write channel into the read-only config shadow.
interface cfg_ro_shadow_if;
  logic        upd_valid;
  logic        upd_ready;
  logic [7:0]  upd_addr;
  logic [31:0] upd_data;
  logic        upd_commit;

  modport master (
    output upd_valid,
    output upd_addr,
    output upd_data,
    output upd_commit,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_addr,
    input  upd_data,
    input  upd_commit,
    output upd_ready
  );
endinterface

// File: rtl/cfg_ro_shadow.sv
// Shadow of read-only config-space values. Values are loaded through the
// update channel, sanity-checked one function per cycle, then locked.
module cfg_ro_shadow #(
  parameter int          NUM_FUNC  = 1,
  parameter int          TIMEOUT   = 1024,
  parameter logic [15:0] DEF_SSID  = 16'h0667,
  parameter logic [15:0] DEF_SSVID = 16'h1014,
  parameter logic [63:0] DEF_DSN   = 64'hDEAD_DEAD_DEAD_DEAD,
  parameter logic [63:0] DEF_BAR0  = 64'hFFFF_FFFF_FC00_0000,
  parameter logic [4:0]  DEF_PASID = 5'd9,
  parameter logic [11:0] DEF_ACTAG = 12'h020
) (
  input  logic                     clock,
  input  logic                     reset_n,
  cfg_ro_shadow_if.slave           upd,
  output logic                     cfg_ro_valid,
  output logic                     upd_err_addr,
  output logic [NUM_FUNC-1:0]      upd_err_func,
  output logic [15:0]              f0_ro_csh_subsystem_id,
  output logic [15:0]              f0_ro_csh_subsystem_vendor_id,
  output logic [63:0]              f0_ro_dsn_serial_number,
  output logic [64*NUM_FUNC-1:0]   fn_ro_csh_mmio_bar0_size,
  output logic [5*NUM_FUNC-1:0]    fn_ro_pasid_max_pasid_width,
  output logic [5*NUM_FUNC-1:0]    fn_ro_octrl00_pasid_len_supported,
  output logic [12*NUM_FUNC-1:0]   fn_ro_octrl00_actag_len_supported
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int FW = (NUM_FUNC > 1) ? $clog2(NUM_FUNC) : 1;

  typedef enum logic [1:0] {LOAD, CHECK, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] load_cnt_q;
  logic [FW-1:0] chk_f_q;
  logic          wr_acc, timeout_hit, last_chk;
  logic          glob_hit, fn_hit;
  logic          unused_data_bits;

  logic [15:0]   ssid_q, ssvid_q;
  logic [63:0]   dsn_q;
  logic [63:0]   bar0_q      [NUM_FUNC];
  logic [4:0]    max_pasid_q [NUM_FUNC];
  logic [4:0]    pasid_len_q [NUM_FUNC];
  logic [11:0]   actag_q     [NUM_FUNC];

  // A size mask is legal when it is a run of ones from bit 63 down to at
  // least bit 20, zeros below: its complement plus one is then a power of two.
  function automatic logic bar0_ok(input logic [63:0] m);
    logic [63:0] inv;
    inv = ~m;
    return m[63] && (m[19:0] == 20'd0) && ((inv & (inv + 64'd1)) == 64'd0);
  endfunction

  assign wr_acc      = upd.upd_valid && (state_q == LOAD);
  assign timeout_hit = (TIMEOUT != 0) && (load_cnt_q == CW'(TIMEOUT - 1));
  assign last_chk    = (chk_f_q == FW'(NUM_FUNC - 1));
  assign glob_hit    = (upd.upd_addr <= 8'h02);
  assign fn_hit      = (upd.upd_addr[7:4] == 4'h1) &&
                       (32'(upd.upd_addr[3:2]) < NUM_FUNC) &&
                       (upd.upd_addr[1:0] != 2'd3);
  assign unused_data_bits = ^{upd.upd_data[31:28], upd.upd_data[15:13], upd.upd_data[7:5]};

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= LOAD;
    else          state_q <= state_d;
  end

  // Next state and handshake/status outputs
  always_comb begin
    state_d       = state_q;
    upd.upd_ready = 1'b0;
    cfg_ro_valid  = 1'b0;
    case (state_q)
      LOAD: begin
        upd.upd_ready = 1'b1;
        if (upd.upd_commit || timeout_hit) state_d = CHECK;
      end
      CHECK:   if (last_chk) state_d = LOCKED;
      LOCKED:  cfg_ro_valid = 1'b1;
      default: state_d = LOAD;
    endcase
  end

  // Load-cycle counter and check-phase function index
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      load_cnt_q <= '0;
      chk_f_q    <= '0;
    end else begin
      if (state_q == LOAD)  load_cnt_q <= load_cnt_q + CW'(1);
      if (state_q == CHECK) chk_f_q    <= chk_f_q + FW'(1);
    end
  end

  // Value registers: written during LOAD, corrected one function per CHECK cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ssid_q       <= DEF_SSID;
      ssvid_q      <= DEF_SSVID;
      dsn_q        <= DEF_DSN;
      upd_err_addr <= 1'b0;
      upd_err_func <= '0;
      for (int unsigned f = 0; f < NUM_FUNC; f++) begin
        bar0_q[f]      <= DEF_BAR0;
        max_pasid_q[f] <= DEF_PASID;
        pasid_len_q[f] <= DEF_PASID;
        actag_q[f]     <= DEF_ACTAG;
      end
    end else if (wr_acc) begin
      if (!glob_hit && !fn_hit) upd_err_addr <= 1'b1;
      case (upd.upd_addr)
        8'h00: begin
          ssvid_q <= upd.upd_data[31:16];
          ssid_q  <= upd.upd_data[15:0];
        end
        8'h01:   dsn_q[31:0]  <= upd.upd_data;
        8'h02:   dsn_q[63:32] <= upd.upd_data;
        default: ;
      endcase
      for (int unsigned f = 0; f < NUM_FUNC; f++) begin
        if (fn_hit && (upd.upd_addr[3:2] == 2'(f))) begin
          case (upd.upd_addr[1:0])
            2'd0: bar0_q[f][31:0]  <= upd.upd_data;
            2'd1: bar0_q[f][63:32] <= upd.upd_data;
            2'd2: begin
              actag_q[f]     <= upd.upd_data[27:16];
              pasid_len_q[f] <= upd.upd_data[12:8];
              max_pasid_q[f] <= upd.upd_data[4:0];
            end
            default: ;
          endcase
        end
      end
    end else if (state_q == CHECK) begin
      for (int unsigned f = 0; f < NUM_FUNC; f++) begin
        if (chk_f_q == FW'(f)) begin
          if (!bar0_ok(bar0_q[f])) begin
            bar0_q[f]       <= DEF_BAR0;
            upd_err_func[f] <= 1'b1;
          end
          if (pasid_len_q[f] > max_pasid_q[f]) begin
            pasid_len_q[f]  <= max_pasid_q[f];
            upd_err_func[f] <= 1'b1;
          end
        end
      end
    end
  end

  assign f0_ro_csh_subsystem_id        = ssid_q;
  assign f0_ro_csh_subsystem_vendor_id = ssvid_q;
  assign f0_ro_dsn_serial_number       = dsn_q;

  for (genvar g = 0; g < NUM_FUNC; g++) begin : g_fn_out
    assign fn_ro_csh_mmio_bar0_size[64*g +: 64]          = bar0_q[g];
    assign fn_ro_pasid_max_pasid_width[5*g +: 5]         = max_pasid_q[g];
    assign fn_ro_octrl00_pasid_len_supported[5*g +: 5]   = pasid_len_q[g];
    assign fn_ro_octrl00_actag_len_supported[12*g +: 12] = actag_q[g];
  end

endmodule

// File: tb/tb_cfg_ro_shadow.sv
// Bench for cfg_ro_shadow: a two-function instance with a short timeout is
// driven by directed and random update traffic against a reference model;
// a single-function default instance covers the minimal commit path.
module tb_cfg_ro_shadow;

  localparam int          NF     = 2;
  localparam int          TO     = 16;
  localparam logic [15:0] D_SSID  = 16'h0667;
  localparam logic [15:0] D_SSVID = 16'h1014;
  localparam logic [63:0] D_DSN   = 64'hDEAD_DEAD_DEAD_DEAD;
  localparam logic [63:0] D_BAR0  = 64'hFFFF_FFFF_FC00_0000;
  localparam logic [4:0]  D_PASID = 5'd9;
  localparam logic [11:0] D_ACTAG = 12'h020;

  logic clock = 1'b0;
  logic rst_a, rst_b;
  always #5 clock = ~clock;

  cfg_ro_shadow_if upd_a ();
  cfg_ro_shadow_if upd_b ();

  logic              a_valid, a_err_addr;
  logic [NF-1:0]     a_err_func;
  logic [15:0]       a_ssid, a_ssvid;
  logic [63:0]       a_dsn;
  logic [64*NF-1:0]  a_bar0;
  logic [5*NF-1:0]   a_maxp, a_plen;
  logic [12*NF-1:0]  a_actag;

  logic              b_valid, b_err_addr;
  logic [0:0]        b_err_func;
  logic [15:0]       b_ssid, b_ssvid;
  logic [63:0]       b_dsn, b_bar0;
  logic [4:0]        b_maxp, b_plen;
  logic [11:0]       b_actag;

  cfg_ro_shadow #(.NUM_FUNC(NF), .TIMEOUT(TO)) dut_a (
    .clock(clock), .reset_n(rst_a), .upd(upd_a),
    .cfg_ro_valid(a_valid), .upd_err_addr(a_err_addr), .upd_err_func(a_err_func),
    .f0_ro_csh_subsystem_id(a_ssid), .f0_ro_csh_subsystem_vendor_id(a_ssvid),
    .f0_ro_dsn_serial_number(a_dsn), .fn_ro_csh_mmio_bar0_size(a_bar0),
    .fn_ro_pasid_max_pasid_width(a_maxp), .fn_ro_octrl00_pasid_len_supported(a_plen),
    .fn_ro_octrl00_actag_len_supported(a_actag)
  );

  cfg_ro_shadow #(.NUM_FUNC(1)) dut_b (
    .clock(clock), .reset_n(rst_b), .upd(upd_b),
    .cfg_ro_valid(b_valid), .upd_err_addr(b_err_addr), .upd_err_func(b_err_func),
    .f0_ro_csh_subsystem_id(b_ssid), .f0_ro_csh_subsystem_vendor_id(b_ssvid),
    .f0_ro_dsn_serial_number(b_dsn), .fn_ro_csh_mmio_bar0_size(b_bar0),
    .fn_ro_pasid_max_pasid_width(b_maxp), .fn_ro_octrl00_pasid_len_supported(b_plen),
    .fn_ro_octrl00_actag_len_supported(b_actag)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model of instance A. m_phase: 0 loading, 1 checking, 2 locked.
  int          m_phase, m_cycles, m_chk;
  logic [15:0] m_ssid, m_ssvid;
  logic [63:0] m_dsn;
  logic [63:0] m_bar0 [NF];
  logic [4:0]  m_maxp [NF];
  logic [4:0]  m_plen [NF];
  logic [11:0] m_actag[NF];
  logic        m_err_addr;
  logic [NF-1:0] m_err_func;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Legal mask: n leading ones (1..44 so bits[19:0] stay clear), nothing after.
  function automatic bit bar0_valid(input logic [63:0] m);
    int n;
    n = 0;
    while (n < 64 && m[63-n] === 1'b1) n++;
    if (n == 0 || n > 44) return 1'b0;
    return (m << n) == 64'd0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cycles = 0; m_chk = 0;
    m_ssid = D_SSID; m_ssvid = D_SSVID; m_dsn = D_DSN;
    m_err_addr = 1'b0; m_err_func = '0;
    for (int f = 0; f < NF; f++) begin
      m_bar0[f] = D_BAR0; m_maxp[f] = D_PASID; m_plen[f] = D_PASID; m_actag[f] = D_ACTAG;
    end
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d);
    int off, f, r;
    off = int'(a) - 16;
    f = off / 4;
    r = off % 4;
    if (a == 8'h00) begin
      m_ssvid = d[31:16]; m_ssid = d[15:0];
    end else if (a == 8'h01) m_dsn[31:0] = d;
    else if (a == 8'h02) m_dsn[63:32] = d;
    else if (off >= 0 && f < NF && r != 3) begin
      if (r == 0)      m_bar0[f][31:0]  = d;
      else if (r == 1) m_bar0[f][63:32] = d;
      else begin
        m_actag[f] = d[27:16]; m_plen[f] = d[12:8]; m_maxp[f] = d[4:0];
      end
    end else m_err_addr = 1'b1;
  endtask

  task automatic model_check(input int f);
    if (!bar0_valid(m_bar0[f])) begin
      m_bar0[f] = D_BAR0; m_err_func[f] = 1'b1;
    end
    if (m_plen[f] > m_maxp[f]) begin
      m_plen[f] = m_maxp[f]; m_err_func[f] = 1'b1;
    end
  endtask

  task automatic model_edge(input logic v, input logic [7:0] a, input logic [31:0] d, input logic c);
    if (m_phase == 0) begin
      if (v) model_write(a, d);
      m_cycles++;
      if (c || m_cycles == TO) begin
        m_phase = 1; m_chk = 0;
      end
    end else if (m_phase == 1) begin
      model_check(m_chk);
      m_chk++;
      if (m_chk == NF) m_phase = 2;
    end
  endtask

  task automatic compare_all();
    logic [64*NF-1:0] eb;
    logic [5*NF-1:0]  em, el;
    logic [12*NF-1:0] ea;
    for (int f = 0; f < NF; f++) begin
      eb[64*f +: 64] = m_bar0[f];
      em[5*f +: 5]   = m_maxp[f];
      el[5*f +: 5]   = m_plen[f];
      ea[12*f +: 12] = m_actag[f];
    end
    check("cfg_ro_valid", 128'(a_valid), 128'(m_phase == 2));
    check("err_addr", 128'(a_err_addr), 128'(m_err_addr));
    check("err_func", 128'(a_err_func), 128'(m_err_func));
    check("ssid", 128'(a_ssid), 128'(m_ssid));
    check("ssvid", 128'(a_ssvid), 128'(m_ssvid));
    check("dsn", 128'(a_dsn), 128'(m_dsn));
    check("bar0", 128'(a_bar0), 128'(eb));
    check("max_pasid", 128'(a_maxp), 128'(em));
    check("pasid_len", 128'(a_plen), 128'(el));
    check("actag", 128'(a_actag), 128'(ea));
  endtask

  // One clock of instance A: present inputs, check ready, clock, update model, compare.
  task automatic cyc_a(input logic v, input logic [7:0] a, input logic [31:0] d, input logic c);
    upd_a.upd_valid = v; upd_a.upd_addr = a; upd_a.upd_data = d; upd_a.upd_commit = c;
    check("upd_ready", 128'(upd_a.upd_ready), 128'(m_phase == 0));
    @(posedge clock);
    model_edge(v, a, d, c);
    #1;
    upd_a.upd_valid = 1'b0; upd_a.upd_commit = 1'b0;
    compare_all();
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) cyc_a(1'b0, 8'h00, 32'h0, 1'b0);
  endtask

  // Asynchronous reset of A: outputs must return to defaults before any clock edge.
  task automatic reset_a();
    upd_a.upd_valid = 1'b0; upd_a.upd_commit = 1'b0;
    rst_a = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(posedge clock);
    #1;
    rst_a = 1'b1;
  endtask

  function automatic logic [7:0] rand_addr();
    int r;
    r = $urandom_range(0, 11);
    if (r < 3) return 8'(r);
    if (r < 9) return 8'(16 + 4 * $urandom_range(0, 1) + (r - 3) % 3);
    if (r == 9) return 8'(8'h13 + 4 * $urandom_range(0, 3));
    return 8'($urandom);
  endfunction

  function automatic logic [31:0] rand_data(input logic [7:0] a);
    logic [63:0] m;
    int k;
    k = $urandom_range(16, 63);
    m = ~((64'd1 << k) - 64'd1);
    if (a[7:4] == 4'h1 && a[1] == 1'b0 && $urandom_range(0, 2) != 0)
      return a[0] ? m[63:32] : m[31:0];
    return $urandom;
  endfunction

  initial begin
    upd_a.upd_valid = 1'b0; upd_a.upd_addr = '0; upd_a.upd_data = '0; upd_a.upd_commit = 1'b0;
    upd_b.upd_valid = 1'b0; upd_b.upd_addr = '0; upd_b.upd_data = '0; upd_b.upd_commit = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    #1;
    rst_b = 1'b0;
    reset_a();
    rst_b = 1'b1;

    // Single-function instance: commit on cycle 1, locked two cycles later.
    check("b_ready_rst", 128'(upd_b.upd_ready), 128'(1));
    check("b_valid_rst", 128'(b_valid), 128'(0));
    upd_b.upd_commit = 1'b1;
    @(posedge clock); #1;
    upd_b.upd_commit = 1'b0;
    check("b_valid_c1", 128'(b_valid), 128'(0));
    check("b_ready_c1", 128'(upd_b.upd_ready), 128'(0));
    @(posedge clock); #1;
    check("b_valid_c2", 128'(b_valid), 128'(1));
    check("b_ssid", 128'(b_ssid), 128'(16'h0667));
    check("b_ssvid", 128'(b_ssvid), 128'(16'h1014));
    check("b_bar0", 128'(b_bar0), 128'(64'hFFFF_FFFF_FC00_0000));
    check("b_err_func", 128'(b_err_func), 128'(0));

    // Defaults on A, then ssid/dsn load with explicit commit.
    check("a_bar0_def", 128'(a_bar0), {D_BAR0, D_BAR0});
    cyc_a(1'b1, 8'h00, 32'h1014_0999, 1'b0);
    cyc_a(1'b1, 8'h01, 32'h1234_5678, 1'b0);
    cyc_a(1'b0, 8'h00, 32'h0, 1'b1);
    idle_a(NF + 1);
    check("ld_ssid", 128'(a_ssid), 128'(16'h0999));
    check("ld_dsn_lo", 128'(a_dsn[31:0]), 128'(32'h1234_5678));
    check("ld_errs", 128'({a_err_addr, a_err_func}), 128'(0));

    // Non-contiguous bar0 on function 1 is restored to default.
    reset_a();
    cyc_a(1'b1, 8'h15, 32'hFFFF_0000, 1'b0);
    cyc_a(1'b1, 8'h14, 32'h0000_0001, 1'b0);
    cyc_a(1'b0, 8'h00, 32'h0, 1'b1);
    idle_a(NF);
    check("bar0_f1_restored", 128'(a_bar0[127:64]), 128'(D_BAR0));
    check("bar0_err_func", 128'(a_err_func), 128'(2'b10));
    check("bar0_locked", 128'(a_valid), 128'(1));

    // pasid_len above max is clamped; write and commit in the same cycle.
    reset_a();
    cyc_a(1'b1, 8'h12, 32'h0020_0C05, 1'b1);
    idle_a(NF);
    check("pasid_clamped", 128'(a_plen[4:0]), 128'(5));
    check("pasid_max", 128'(a_maxp[4:0]), 128'(5));
    check("pasid_err_func", 128'(a_err_func), 128'(2'b01));

    // Timeout: still loading after 15 cycles, checking after 16; locked ignores writes.
    reset_a();
    idle_a(TO - 1);
    check("to_pre_ready", 128'(upd_a.upd_ready), 128'(1));
    idle_a(1);
    check("to_post_ready", 128'(upd_a.upd_ready), 128'(0));
    idle_a(NF);
    cyc_a(1'b1, 8'h00, 32'hAAAA_BBBB, 1'b1);
    check("locked_ssid", 128'(a_ssid), 128'(D_SSID));
    check("locked_err_addr", 128'(a_err_addr), 128'(0));

    // Unmapped write flags an error only; reset in LOCKED restores defaults.
    reset_a();
    cyc_a(1'b1, 8'h50, 32'h1234_5678, 1'b0);
    check("unmapped_err", 128'(a_err_addr), 128'(1));
    cyc_a(1'b1, 8'h1C, 32'h0000_0001, 1'b1);
    idle_a(NF + 1);
    reset_a();
    check("rst_valid", 128'(a_valid), 128'(0));
    check("rst_ssid", 128'(a_ssid), 128'(D_SSID));

    // Random traffic, with occasional reset while checking.
    for (int s = 0; s < 12; s++) begin
      int n;
      logic [7:0] a;
      reset_a();
      n = $urandom_range(8, 30);
      for (int i = 0; i < n; i++) begin
        if (s % 4 == 3 && m_phase == 1 && $urandom_range(0, 1) == 1) reset_a();
        a = rand_addr();
        cyc_a(1'($urandom_range(0, 3) != 0), a, rand_data(a), 1'($urandom_range(0, 15) == 0));
      end
      idle_a(TO + NF + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
